// File: rtl/xor_stream_arbiter.sv
// Round-robin arbiter sharing one xors_to_stream converter between two match engines.
// Registers the granted block onto the converter inputs and enforces the minimum issue spacing.
module xor_stream_arbiter #(
    parameter int BLK_W     = 16,
    parameter int BLK_H     = 16,
    parameter int ISSUE_GAP = 256,
    parameter int CNT_W     = 16
) (
    input  logic                   clk50,
    input  logic                   reset,
    input  logic [BLK_H*BLK_W-1:0] req0_xors,
    input  logic [7:0]             req0_conf,
    input  logic [7:0]             req0_coords,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [BLK_H*BLK_W-1:0] req1_xors,
    input  logic [7:0]             req1_conf,
    input  logic [7:0]             req1_coords,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic                   fifo_almost_full,
    output logic [BLK_H*BLK_W-1:0] xors_out,
    output logic [7:0]             conf_out,
    output logic [7:0]             coords_out,
    output logic                   xors_valid,
    output logic                   src_id,
    output logic [CNT_W-1:0]       issue_count,
    output logic                   busy
);
    localparam int GAP_W = (ISSUE_GAP > 2) ? $clog2(ISSUE_GAP - 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(ISSUE_GAP - 2);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       state;
    logic [GAP_W-1:0] gap_cnt;
    logic             last_grant;
    logic             eligible;
    logic             grant0;
    logic             grant1;
    logic             accept;

    // Readies are gated by reset so nothing is handed over while reset is held.
    always_comb begin
        eligible = reset && (state == ST_IDLE) && !fifo_almost_full;
        grant0   = eligible && req0_valid && (!req1_valid || last_grant);
        grant1   = eligible && req1_valid && (!req0_valid || !last_grant);
        accept   = grant0 || grant1;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state == ST_BUSY);

    always_ff @(posedge clk50) begin
        if (!reset) begin
            state       <= ST_IDLE;
            gap_cnt     <= '0;
            last_grant  <= 1'b1;
            xors_out    <= '0;
            conf_out    <= '0;
            coords_out  <= '0;
            src_id      <= 1'b0;
            issue_count <= '0;
            xors_valid  <= 1'b0;
        end else begin
            xors_valid <= accept;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        xors_out    <= grant1 ? req1_xors   : req0_xors;
                        conf_out    <= grant1 ? req1_conf   : req0_conf;
                        coords_out  <= grant1 ? req1_coords : req0_coords;
                        src_id      <= grant1;
                        last_grant  <= grant1;
                        issue_count <= issue_count + CNT_W'(1);
                        gap_cnt     <= GAP_LOAD;
                        state       <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (gap_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
